div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle iterative divider with its sequencing controller, owning the HI/LO result path. It accepts DIV/DIVU requests from the execute stage and runs a radix-2 restoring division, one quotient bit per cycle. It delivers the remainder and quotient as a one-cycle write pulse on HasDivW/DivHiW/DivLoW into the decode stage's HI/LO registers. It also raises a stall to the hazard unit while a new divide or an MFHI/MFLO in decode must wait for the result.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- HasDivE  in  1  divide request from execute; held high until accepted
- IsSignedE  in  1  1 = DIV, 0 = DIVU (used only with DIV_SIGNED_EN)
- DividendE  in  WIDTH  rs operand
- DivisorE  in  WIDTH  rt operand
- MfOpInD  in  1  MFHI/MFLO currently in decode
- HasDivW  out  1  one-cycle pulse: write DivHiW/DivLoW into HI/LO
- DivHiW  out  WIDTH  remainder
- DivLoW  out  WIDTH  quotient
- DivBusy  out  1  high in any state other than IDLE
- StallDiv  out  1  to hazard unit: stall fetch/decode/execute

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - HasDivE=1 accepts the request: latch operands (magnitudes if signed; see Configuration), clear partial remainder, count=0.
  - Divisor==0 goes directly to DONE. Otherwise go to RUN.
- RUN, each cycle:
  - rem' = {rem[WIDTH-2:0], q[WIDTH-1]}; q = q<<1.
  - If rem' >= divisor: rem' -= divisor and set q[0].
  - count increments; after iteration WIDTH (count==WIDTH-1 on entry) go to DONE.
- DONE: apply sign correction, register DivHiW=remainder and DivLoW=quotient, pulse HasDivW, then return to IDLE.
- Divide by zero: DivLoW = all ones, DivHiW = original dividend. No exception is raised.
- StallDiv = (state != IDLE) & (HasDivE | MfOpInD). Requests are accepted only in IDLE; a request arriving in RUN or DONE stalls until IDLE.
- The compare/subtract uses a WIDTH+1-bit difference so the borrow is the compare result.
- DivHiW/DivLoW hold the last result between pulses.

## Timing
- Reset (asynchronous): state=IDLE, HasDivW=0, DivHiW=0, DivLoW=0, DivBusy=0, StallDiv=0, count=0. Reset mid-RUN or mid-DONE aborts the divide with no HasDivW pulse and leaves the result registers zero.
- Request accepted at edge N (IDLE, HasDivE=1):
  - RUN occupies cycles N+1..N+WIDTH.
  - DONE occupies cycle N+WIDTH+1, with HasDivW high in that cycle.
  - IDLE resumes at N+WIDTH+2.
  - Latency is WIDTH+2 cycles, i.e. 34 for WIDTH=32.
- Divide by zero: DONE is in cycle N+1 and HasDivW is high in that cycle (latency 2).
- An MFHI/MFLO in decode stalls through the DONE cycle and proceeds in the following cycle, so it sees the new HI/LO.
- Back-to-back divides: the second request, held from the DONE cycle, is accepted on the first IDLE edge. The minimum request spacing is WIDTH+2 cycles.
- StallDiv is combinational from state and inputs; HasDivW is registered.

## Configuration
- DIV_SIGNED_EN defined: IsSignedE=1 selects signed division.
  - Operands are latched as magnitudes, and the signs are recorded.
  - In DONE, the quotient is negated when the sign of the dividend differs from the sign of the divisor.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / -1 yields DivLoW=0x80000000, DivHiW=0.
  - Signed divide by zero yields DivLoW=all ones, DivHiW=dividend.
- DIV_SIGNED_EN undefined: IsSignedE is ignored, all divides are unsigned, and no sign logic is synthesized.

## Test plan
- 100 / 7 unsigned, accepted at cycle 0 -> HasDivW pulse at cycle 33 only, DivLoW=14, DivHiW=2, DivBusy low at cycle 34.
- 0x12345678 / 0 -> HasDivW at cycle 1, DivLoW=0xFFFFFFFF, DivHiW=0x12345678.
- DIV_SIGNED_EN, DIV -7 / 2 -> DivLoW=0xFFFFFFFD, DivHiW=0xFFFFFFFF. With the same operands as DIVU -> DivLoW=0x7FFFFFFC, DivHiW=1.
- Divide in flight, MfOpInD=1 at cycle 5 -> StallDiv high during cycles 5..33 and low at cycle 34; a second HasDivE held from cycle 10 is accepted at the cycle-34 edge, with its result pulse at cycle 67.
- Reset asserted asynchronously at cycle 15 of a divide -> all outputs 0 immediately, no HasDivW pulse; a subsequent 9 / 3 gives DivLoW=3, DivHiW=0.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Request/result bundle between the execute/decode stages and the iterative divider.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             HasDivE;
    logic             IsSignedE;
    logic [WIDTH-1:0] DividendE;
    logic [WIDTH-1:0] DivisorE;
    logic             MfOpInD;
    logic             HasDivW;
    logic [WIDTH-1:0] DivHiW;
    logic [WIDTH-1:0] DivLoW;
    logic             DivBusy;
    logic             StallDiv;

    modport master (
        output HasDivE, IsSignedE, DividendE, DivisorE, MfOpInD,
        input  HasDivW, DivHiW, DivLoW, DivBusy, StallDiv
    );

    modport slave (
        input  HasDivE, IsSignedE, DividendE, DivisorE, MfOpInD,
        output HasDivW, DivHiW, DivLoW, DivBusy, StallDiv
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider with HI/LO writeback pulse and hazard stall.
// Optional signed DIV support is compiled in with `define DIV_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for HasDivE; requests are accepted only here
// RUN   | one quotient bit per cycle, WIDTH iterations
// DONE  | result registered, HasDivW high for this single cycle
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    div_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

    // rem < dvs always holds, so when rem's MSB shifts out the shifted value
    // certainly exceeds dvs and the WIDTH+1-bit difference is still exact.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign take    = rem[WIDTH-1] | ~diff[WIDTH];
    assign rem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], take};

`ifdef DIV_SIGNED_EN
    logic dvd_neg;
    logic dvs_neg;
    logic neg_q;
    logic neg_r;

    assign dvd_neg = bus.IsSignedE & bus.DividendE[WIDTH-1];
    assign dvs_neg = bus.IsSignedE & bus.DivisorE[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~bus.DividendE + 1'b1) : bus.DividendE;
    assign dvs_mag = dvs_neg ? (~bus.DivisorE + 1'b1) : bus.DivisorE;
    assign quo_res = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    assign rem_res = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && bus.HasDivE) begin
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
        end
    end
`else
    assign dvd_mag = bus.DividendE;
    assign dvs_mag = bus.DivisorE;
    assign quo_res = quo_nxt;
    assign rem_res = rem_nxt;
`endif

    assign bus.StallDiv = (state != IDLE) & (bus.HasDivE | bus.MfOpInD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            bus.HasDivW <= 1'b0;
            bus.DivHiW  <= '0;
            bus.DivLoW  <= '0;
            bus.DivBusy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.HasDivW <= 1'b0;
                    if (bus.HasDivE) begin
                        count       <= '0;
                        rem         <= '0;
                        quo         <= dvd_mag;
                        dvs         <= dvs_mag;
                        bus.DivBusy <= 1'b1;
                        if (bus.DivisorE == '0) begin
                            state       <= DONE;
                            bus.HasDivW <= 1'b1;
                            bus.DivLoW  <= '1;
                            bus.DivHiW  <= bus.DividendE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    count <= count + 1'b1;
                    // Final iteration writes the corrected result so it is valid during DONE.
                    if (count == LAST) begin
                        state       <= DONE;
                        bus.HasDivW <= 1'b1;
                        bus.DivLoW  <= quo_res;
                        bus.DivHiW  <= rem_res;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.HasDivW <= 1'b0;
                    bus.DivBusy <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    bus.HasDivW <= 1'b0;
                    bus.DivBusy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, divide-by-zero, stall, back-to-back, reset abort.
module tb_div_sequencer;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    div_sequencer_if #(.WIDTH(32)) dbus ();

    div_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dbus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present a request before the next edge; returns #1 into cycle 1 with HasDivE dropped.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        dbus.DividendE = a;
        dbus.DivisorE  = b;
        dbus.IsSignedE = sgn;
        dbus.HasDivE   = 1'b1;
        @(posedge clock);
        #1;
        dbus.HasDivE   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_cmp++; if (dbus.HasDivW !== 1'b0) begin n_err++; $display("FAIL reset_hasdivw got %0b want 0", dbus.HasDivW); end
        n_cmp++; if (dbus.DivHiW !== 32'h0) begin n_err++; $display("FAIL reset_divhiw got %h want 0", dbus.DivHiW); end
        n_cmp++; if (dbus.DivLoW !== 32'h0) begin n_err++; $display("FAIL reset_divlow got %h want 0", dbus.DivLoW); end
        n_cmp++; if (dbus.DivBusy !== 1'b0) begin n_err++; $display("FAIL reset_divbusy got %0b want 0", dbus.DivBusy); end
        n_cmp++; if (dbus.StallDiv !== 1'b0) begin n_err++; $display("FAIL reset_stalldiv got %0b want 0", dbus.StallDiv); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_latency();
        start_div(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 36; c++) begin
            if (c > 1) begin
                @(posedge clock);
                #1;
            end
            n_cmp++;
            if (dbus.HasDivW !== (c == 33)) begin
                n_err++; $display("FAIL lat_hasdivw cycle %0d got %0b want %0b", c, dbus.HasDivW, (c == 33));
            end
            n_cmp++;
            if (dbus.DivBusy !== (c <= 33)) begin
                n_err++; $display("FAIL lat_divbusy cycle %0d got %0b want %0b", c, dbus.DivBusy, (c <= 33));
            end
            if (c == 33) begin
                n_cmp++; if (dbus.DivLoW !== 32'd14) begin n_err++; $display("FAIL lat_divlow got %h want %h", dbus.DivLoW, 32'd14); end
                n_cmp++; if (dbus.DivHiW !== 32'd2) begin n_err++; $display("FAIL lat_divhiw got %h want %h", dbus.DivHiW, 32'd2); end
            end
        end
        n_cmp++; if (dbus.DivLoW !== 32'd14) begin n_err++; $display("FAIL lat_hold_low got %h want %h", dbus.DivLoW, 32'd14); end
    endtask

    task automatic test_div_zero();
        start_div(32'h12345678, 32'h0, 1'b0);
        n_cmp++; if (dbus.HasDivW !== 1'b1) begin n_err++; $display("FAIL dz_hasdivw got %0b want 1", dbus.HasDivW); end
        n_cmp++; if (dbus.DivLoW !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_divlow got %h want ffffffff", dbus.DivLoW); end
        n_cmp++; if (dbus.DivHiW !== 32'h12345678) begin n_err++; $display("FAIL dz_divhiw got %h want 12345678", dbus.DivHiW); end
        @(posedge clock);
        #1;
        n_cmp++; if (dbus.HasDivW !== 1'b0) begin n_err++; $display("FAIL dz_pulse_end got %0b want 0", dbus.HasDivW); end
        n_cmp++; if (dbus.DivBusy !== 1'b0) begin n_err++; $display("FAIL dz_idle got %0b want 0", dbus.DivBusy); end
        n_cmp++; if (dbus.DivHiW !== 32'h12345678) begin n_err++; $display("FAIL dz_hold_hi got %h want 12345678", dbus.DivHiW); end
    endtask

    task automatic test_vectors();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vs [5];
        logic [31:0] eq [5];
        logic [31:0] er [5];
        va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        vs[0] = 1'b0; eq[0] = 32'h7FFFFFFC; er[0] = 32'd1;
        va[1] = 32'd5;        vb[1] = 32'd7;        vs[1] = 1'b0; eq[1] = 32'd0;        er[1] = 32'd5;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'd1;        vs[2] = 1'b0; eq[2] = 32'hFFFFFFFF; er[2] = 32'd0;
`ifdef DIV_SIGNED_EN
        va[3] = 32'hFFFFFFF9; vb[3] = 32'd2;        vs[3] = 1'b1; eq[3] = 32'hFFFFFFFD; er[3] = 32'hFFFFFFFF;
        va[4] = 32'h80000000; vb[4] = 32'hFFFFFFFF; vs[4] = 1'b1; eq[4] = 32'h80000000; er[4] = 32'd0;
`else
        // IsSignedE has no effect in the unsigned-only build.
        va[3] = 32'hFFFFFFF9; vb[3] = 32'd2;        vs[3] = 1'b1; eq[3] = 32'h7FFFFFFC; er[3] = 32'd1;
        va[4] = 32'h80000000; vb[4] = 32'hFFFFFFFF; vs[4] = 1'b1; eq[4] = 32'd0;        er[4] = 32'h80000000;
`endif
        for (int i = 0; i < 5; i++) begin
            start_div(va[i], vb[i], vs[i]);
            repeat (32) @(posedge clock);
            #1;
            n_cmp++; if (dbus.HasDivW !== 1'b1) begin n_err++; $display("FAIL vec%0d_hasdivw got %0b want 1", i, dbus.HasDivW); end
            n_cmp++; if (dbus.DivLoW !== eq[i]) begin n_err++; $display("FAIL vec%0d_divlow got %h want %h", i, dbus.DivLoW, eq[i]); end
            n_cmp++; if (dbus.DivHiW !== er[i]) begin n_err++; $display("FAIL vec%0d_divhiw got %h want %h", i, dbus.DivHiW, er[i]); end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic exp_stall;
        logic exp_w;
        start_div(32'd1000, 32'd10, 1'b0);
        for (int c = 1; c <= 70; c++) begin
            if (c > 1) begin
                @(posedge clock);
                #1;
            end
            dbus.MfOpInD = (c >= 5 && c <= 33);
            if (c >= 10 && c <= 34) begin
                dbus.HasDivE   = 1'b1;
                dbus.DividendE = 32'hDEADBEEF;
                dbus.DivisorE  = 32'h10;
            end else begin
                dbus.HasDivE = 1'b0;
            end
            #1;
            exp_stall = (c >= 5 && c <= 33);
            exp_w     = (c == 33 || c == 67);
            n_cmp++;
            if (dbus.StallDiv !== exp_stall) begin
                n_err++; $display("FAIL b2b_stall cycle %0d got %0b want %0b", c, dbus.StallDiv, exp_stall);
            end
            n_cmp++;
            if (dbus.HasDivW !== exp_w) begin
                n_err++; $display("FAIL b2b_hasdivw cycle %0d got %0b want %0b", c, dbus.HasDivW, exp_w);
            end
            if (c == 33) begin
                n_cmp++; if (dbus.DivLoW !== 32'd100) begin n_err++; $display("FAIL b2b_first_low got %h want %h", dbus.DivLoW, 32'd100); end
                n_cmp++; if (dbus.DivHiW !== 32'd0) begin n_err++; $display("FAIL b2b_first_hi got %h want 0", dbus.DivHiW); end
            end
            if (c == 34) begin
                n_cmp++; if (dbus.DivBusy !== 1'b0) begin n_err++; $display("FAIL b2b_idle34 got %0b want 0", dbus.DivBusy); end
            end
            if (c == 35) begin
                n_cmp++; if (dbus.DivBusy !== 1'b1) begin n_err++; $display("FAIL b2b_accept2 got %0b want 1", dbus.DivBusy); end
            end
            if (c == 67) begin
                n_cmp++; if (dbus.DivLoW !== 32'h0DEADBEE) begin n_err++; $display("FAIL b2b_second_low got %h want 0deadbee", dbus.DivLoW); end
                n_cmp++; if (dbus.DivHiW !== 32'hF) begin n_err++; $display("FAIL b2b_second_hi got %h want f", dbus.DivHiW); end
            end
        end
        dbus.MfOpInD = 1'b0;
        dbus.HasDivE = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic seen;
        start_div(32'hFFFF, 32'd3, 1'b0);
        repeat (14) @(posedge clock);
        #1;
        dbus.MfOpInD = 1'b1;
        #1;
        n_cmp++; if (dbus.StallDiv !== 1'b1) begin n_err++; $display("FAIL abort_pre_stall got %0b want 1", dbus.StallDiv); end
        reset = 1'b1;
        #1;
        n_cmp++; if (dbus.HasDivW !== 1'b0) begin n_err++; $display("FAIL abort_hasdivw got %0b want 0", dbus.HasDivW); end
        n_cmp++; if (dbus.DivBusy !== 1'b0) begin n_err++; $display("FAIL abort_divbusy got %0b want 0", dbus.DivBusy); end
        n_cmp++; if (dbus.StallDiv !== 1'b0) begin n_err++; $display("FAIL abort_stalldiv got %0b want 0", dbus.StallDiv); end
        n_cmp++; if (dbus.DivLoW !== 32'h0) begin n_err++; $display("FAIL abort_divlow got %h want 0", dbus.DivLoW); end
        n_cmp++; if (dbus.DivHiW !== 32'h0) begin n_err++; $display("FAIL abort_divhiw got %h want 0", dbus.DivHiW); end
        dbus.MfOpInD = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock);
            #1;
            if (dbus.HasDivW !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_pulse got %0b want 0", seen); end
        n_cmp++; if (dbus.DivLoW !== 32'h0) begin n_err++; $display("FAIL abort_hold_low got %h want 0", dbus.DivLoW); end
        start_div(32'd9, 32'd3, 1'b0);
        repeat (32) @(posedge clock);
        #1;
        n_cmp++; if (dbus.HasDivW !== 1'b1) begin n_err++; $display("FAIL post_hasdivw got %0b want 1", dbus.HasDivW); end
        n_cmp++; if (dbus.DivLoW !== 32'd3) begin n_err++; $display("FAIL post_divlow got %h want 3", dbus.DivLoW); end
        n_cmp++; if (dbus.DivHiW !== 32'd0) begin n_err++; $display("FAIL post_divhiw got %h want 0", dbus.DivHiW); end
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b0;
        dbus.HasDivE   = 1'b0;
        dbus.IsSignedE = 1'b0;
        dbus.DividendE = '0;
        dbus.DivisorE  = '0;
        dbus.MfOpInD   = 1'b0;
        test_reset();
        test_latency();
        test_div_zero();
        test_vectors();
        test_back_to_back();
        @(posedge clock);
        #1;
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
